// File: rtl/top_seq_pkg.sv
// rtl/top_seq_pkg.sv - shared types and constants for the sequencer (TOP_SEQ_CHECK_EN adds the expected-result field)
package top_seq_pkg;

   localparam int DEFAULT_LATENCY = 2;

   typedef logic req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
`ifdef TOP_SEQ_CHECK_EN
      logic    expected;
`endif
   } seq_tag_t;

endpackage

// File: rtl/top_seq_rr_arb.sv
// rtl/top_seq_rr_arb.sv - two-way round-robin arbiter, pointer moves only on an accepted grant
module top_seq_rr_arb (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   // Favoured requester: 0 after reset, otherwise the one not granted last
   logic ptr_q;
   logic ptr_d;

   // One-hot grant; the pointer only breaks ties
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = ptr_q ? 2'b10 : 2'b01;
      end
   end

   // After an accepted grant, favour the other requester
   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = ~grant[1];
      end
   end

   // Pointer register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/top_seq_ctrl.sv
// rtl/top_seq_ctrl.sv - two-requester sequencer for a fixed-latency NAND datapath (option: TOP_SEQ_CHECK_EN)
module top_seq_ctrl
   import top_seq_pkg::*;
#(
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic clock,
   input  logic reset,
   input  logic req0_valid,
   input  logic req0_a,
   input  logic req0_b,
   output logic req0_ready,
   input  logic req1_valid,
   input  logic req1_a,
   input  logic req1_b,
   output logic req1_ready,
   output logic rsp0_valid,
   output logic rsp0_data,
   output logic rsp1_valid,
   output logic rsp1_data,
   output logic dp_in1,
   output logic dp_in2,
   input  logic dp_out,
   output logic busy,
   output logic err
);

   logic [1:0]             req_vec;
   logic [1:0]             grant;
   logic                   hs;
   req_id_t                hs_id;
   logic                   hs_a;
   logic                   hs_b;
   logic                   dp_in1_q;
   logic                   dp_in1_d;
   logic                   dp_in2_q;
   logic                   dp_in2_d;
   seq_tag_t               tag_in;
   seq_tag_t [LATENCY-1:0] pipe_q;
   seq_tag_t [LATENCY-1:0] pipe_d;
   seq_tag_t               rsp_tag_q;
   seq_tag_t               rsp_tag_d;
   logic                   busy_any;

   assign req_vec = {req1_valid, req0_valid};

   top_seq_rr_arb u_arb (
      .clock  (clock),
      .reset  (reset),
      .req    (req_vec),
      .accept (hs),
      .grant  (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   // Pick the granted requester's operands and build the tag that follows it down the pipe
   always_comb begin
      hs     = |grant;
      hs_id  = grant[1];
      hs_a   = grant[1] ? req1_a : req0_a;
      hs_b   = grant[1] ? req1_b : req0_b;
      tag_in = '0;
      tag_in.valid = hs;
      tag_in.id    = hs_id;
`ifdef TOP_SEQ_CHECK_EN
      tag_in.expected = ~(hs_a & hs_b);
`endif
   end

   // Datapath operands hold until the next handshake; tags shift one slot per cycle,
   // the last slot lands in the response stage which lines up with dp_out
   always_comb begin
      dp_in1_d  = hs ? hs_a : dp_in1_q;
      dp_in2_d  = hs ? hs_b : dp_in2_q;
      pipe_d[0] = tag_in;
      for (int i = 1; i < LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      rsp_tag_d = pipe_q[LATENCY-1];
   end

   // Operand and tag registers; reset drops every in-flight operation
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dp_in1_q  <= 1'b0;
         dp_in2_q  <= 1'b0;
         pipe_q    <= '0;
         rsp_tag_q <= '0;
      end else begin
         dp_in1_q  <= dp_in1_d;
         dp_in2_q  <= dp_in2_d;
         pipe_q    <= pipe_d;
         rsp_tag_q <= rsp_tag_d;
      end
   end

   // Outputs: response routed by tag id, data taken live from the datapath
   always_comb begin
      busy_any = rsp_tag_q.valid;
      for (int i = 0; i < LATENCY; i++) begin
         busy_any = busy_any | pipe_q[i].valid;
      end
   end

   assign dp_in1     = dp_in1_q;
   assign dp_in2     = dp_in2_q;
   assign rsp0_valid = rsp_tag_q.valid & ~rsp_tag_q.id;
   assign rsp1_valid = rsp_tag_q.valid &  rsp_tag_q.id;
   assign rsp0_data  = rsp0_valid & dp_out;
   assign rsp1_data  = rsp1_valid & dp_out;
   assign busy       = busy_any;

`ifdef TOP_SEQ_CHECK_EN
   logic err_q;
   logic err_d;

   // Sticky flag, visible in the same cycle as the offending response
   always_comb begin
      err_d = err_q | (rsp_tag_q.valid & (dp_out != rsp_tag_q.expected));
   end

   // Error flag register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_d;
`else
   assign err = 1'b0;
`endif

endmodule
